memb_feed_ctrl: RTL and testbench
=================================

# memb_feed_ctrl

Sequencer for the B-operand skew buffer (memB) of the systolic matrix-multiply datapath. On a start pulse it accepts DIM rows of B from an upstream row source over a valid/ready handshake and drives them into memB with its shift enable. It then feeds 2·DIM−1 zero rows so every skewed column drains fully into the array. Back-pressure from the array stalls the whole sequence without losing or duplicating rows.

## Interface
Parameters:
- BITS_AB, 8, width of one B element (signed)
- DIM, 8, array dimension; rows per matrix and lanes per row

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one matrix sequence; sampled only in IDLE
- row_valid  in  1  upstream row available
- row_data  in  DIM×BITS_AB signed  upstream B row, lane i → memB lane i
- row_ready  out  1  row accepted this cycle when row_valid & row_ready
- sa_ready  in  1  systolic array can advance this cycle
- memb_en  out  1  memB shift enable
- memb_bin  out  DIM×BITS_AB signed  data into memB
- busy  out  1  high in FEED or FLUSH
- done  out  1  one-cycle pulse at end of sequence

Decided: one clock `clk`; reset `rst` is synchronous and active-high.

## Operation
- States: IDLE, FEED, FLUSH.
- IDLE:
  - start=1 → FEED; row counter cleared.
  - start=0 → stay.
- FEED:
  - beat = row_valid & sa_ready.
  - Each beat: memb_en=1, memb_bin=row_data, row counter +1.
  - After beat number DIM → FLUSH; flush counter cleared.
- FLUSH:
  - beat = sa_ready.
  - Each beat: memb_en=1, memb_bin=all zeros, flush counter +1.
  - After beat number 2·DIM−1 → IDLE, and done pulses the next cycle.
- Output decode:
  - row_ready = (state==FEED) & sa_ready.
  - memb_en = beat.
  - Outside a FEED beat, memb_bin is zero.
  - Outputs are combinational from state and inputs; there are no combinational paths from row_data to any control output.
- Counters are $clog2(2·DIM) bits wide; counters never wrap, since the transition occurs at terminal count.
- start while busy: ignored, not queued.
- start in the same cycle that done pulses: accepted, because the state is already IDLE.
- row_valid outside FEED: ignored; row_ready=0.
- Reset mid-sequence: state→IDLE, counters→0, done=0, and no flush is issued. The memB reset is driven by the parent as ~rst, so the skew contents clear in the same cycle.

## Timing
- Reset values:
  - state=IDLE; counters=0.
  - memb_en=0, row_ready=0, busy=0, done=0, memb_bin=0.
- start sampled at edge N → FEED visible in cycle N+1.
- Stall-free sequence: DIM FEED beats, then 2·DIM−1 FLUSH beats.
- done is high in the cycle after the last FLUSH beat, and busy is low in that cycle.
- Total start→done latency with no stalls: 3·DIM cycles (24 for DIM=8).
- Each cycle of sa_ready=0, or row_valid=0 in FEED, adds exactly one cycle. memb_en=0 during the stall; state and counters hold.

## Configuration
- MEMB_FEED_CTRL_PERF_EN:
  - Defined: adds output `stall_cycles` (16 bits, saturating at 16'hFFFF). It counts busy cycles with memb_en=0, clears on start acceptance and on rst, and holds its value after done.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `memb_ctrl_pkg` contains:
  - the state enum (IDLE, FEED, FLUSH);
  - default BITS_AB/DIM localparams;
  - the counter width function.
- Single flat module. No sub-module; memB is instantiated beside this block by the parent, not inside it.

## Test plan
- Stall-free, DIM=8: start at cycle 0, row_valid=1, sa_ready=1 always.
  - 8 memb_en cycles (1–8) carry rows 0–7.
  - 15 cycles (9–23) carry zeros.
  - done=1 at cycle 24 only.
- Source gaps: row_valid=0 for rows 3 and 6 (one cycle each).
  - memb_en=0 in those cycles.
  - Rows are delivered in order with none duplicated; done is at cycle 26.
- Array back-pressure: sa_ready=0 for 4 cycles mid-FLUSH.
  - memb_en=0 and the flush count holds.
  - done is at cycle 28; exactly 15 zero beats in total.
- Reset mid-FEED: rst=1 after row 4.
  - Next cycle: busy=0, memb_en=0, done never pulses.
  - A new start produces a full, clean 24-cycle sequence.
- Start handling:
  - start pulsed while busy is ignored (single done).
  - start asserted in the done cycle begins a second sequence immediately.
- PERF_EN defined, sa_ready low for 5 cycles: stall_cycles=5 after done; it clears on the next start.

Source files
------------

// File: rtl/memb_ctrl_pkg.sv
// Shared definitions for the memB feed sequencer: state encoding,
// default array geometry and the counter width helper.
package memb_ctrl_pkg;

  // Default geometry of the systolic datapath.
  localparam int MEMB_BITS_AB_DEF = 8;
  localparam int MEMB_DIM_DEF     = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2
  } memb_state_e;

  // Row and flush counters both reach at most 2*dim-1, so this width
  // never wraps.
  function automatic int cnt_width(input int dim);
    return $clog2(2 * dim);
  endfunction

endpackage

// File: rtl/memb_feed_ctrl.sv
// memB feed sequencer: accepts DIM B rows from an upstream source and
// shifts them into the skew buffer, then shifts 2*DIM-1 zero rows so
// every skewed column drains into the array. sa_ready stalls every step.
// Optional feature macro: MEMB_FEED_CTRL_PERF_EN adds the 16-bit
// saturating stall_cycles output.
module memb_feed_ctrl
  import memb_ctrl_pkg::*;
#(
  parameter int BITS_AB = MEMB_BITS_AB_DEF,
  parameter int DIM     = MEMB_DIM_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      row_valid,
  input  logic [DIM*BITS_AB-1:0]    row_data,
  output logic                      row_ready,
  input  logic                      sa_ready,
  output logic                      memb_en,
  output logic [DIM*BITS_AB-1:0]    memb_bin,
  output logic                      busy,
  output logic                      done
`ifdef MEMB_FEED_CTRL_PERF_EN
  ,
  output logic [15:0]               stall_cycles
`endif
);

  localparam int CW = cnt_width(DIM);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FEED  = ST_FEED;
  localparam logic [1:0] S_FLUSH = ST_FLUSH;

  // Terminal counts: the transition happens on the last beat, so the
  // counters never need to roll over.
  localparam logic [CW-1:0] ROW_LAST   = CW'(DIM - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * DIM - 2);

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [CW-1:0] r_row_cnt;
  logic [CW-1:0] w_row_cnt_next;
  logic [CW-1:0] r_flush_cnt;
  logic [CW-1:0] w_flush_cnt_next;
  logic          r_done;
  logic          w_done_next;

  logic          w_in_feed;
  logic          w_in_flush;
  logic          w_beat;
  logic          w_feed_beat;

  assign w_in_feed  = (r_state == S_FEED);
  assign w_in_flush = (r_state == S_FLUSH);

  // A beat advances memB by one row; FEED also needs a row from upstream.
  assign w_beat      = sa_ready & ((w_in_feed & row_valid) | w_in_flush);
  assign w_feed_beat = w_beat & w_in_feed;

  assign row_ready = w_in_feed & sa_ready;
  assign memb_en   = w_beat;
  assign busy      = w_in_feed | w_in_flush;
  assign done      = r_done;

  // Lane-wise data gate: upstream row on a FEED beat, zeros otherwise
  // (flush rows and idle cycles alike).
  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    assign memb_bin[gi*BITS_AB +: BITS_AB] =
      w_feed_beat ? row_data[gi*BITS_AB +: BITS_AB] : '0;
  end

  // Next-state and counter decode for the IDLE -> FEED -> FLUSH sequence.
  always_comb begin
    w_state_next     = r_state;
    w_row_cnt_next   = r_row_cnt;
    w_flush_cnt_next = r_flush_cnt;
    w_done_next      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next   = S_FEED;
          w_row_cnt_next = '0;
        end
      end
      S_FEED: begin
        if (w_beat) begin
          w_row_cnt_next = r_row_cnt + CW'(1);
          if (r_row_cnt == ROW_LAST) begin
            w_state_next     = S_FLUSH;
            w_flush_cnt_next = '0;
          end
        end
      end
      S_FLUSH: begin
        if (w_beat) begin
          w_flush_cnt_next = r_flush_cnt + CW'(1);
          if (r_flush_cnt == FLUSH_LAST) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, counters and the registered done pulse; reset abandons any
  // sequence in flight without issuing a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row_cnt   <= '0;
      r_flush_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_row_cnt   <= w_row_cnt_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_done      <= w_done_next;
    end
  end

`ifdef MEMB_FEED_CTRL_PERF_EN
  logic [15:0] r_stall_cnt;

  // Count busy cycles that did not advance memB; cleared when a new
  // sequence is accepted, held after done, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if (busy && !w_beat && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_memb_feed_ctrl.sv
// Directed bench for memb_feed_ctrl: a behavioural model predicts control
// outputs every cycle and a scoreboard queue holds the expected memB rows.
module tb_memb_feed_ctrl;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int W       = DIM * BITS_AB;

  logic         clk;
  logic         rst;
  logic         start;
  logic         row_valid;
  logic [W-1:0] row_data;
  logic         row_ready;
  logic         sa_ready;
  logic         memb_en;
  logic [W-1:0] memb_bin;
  logic         busy;
  logic         done;
`ifdef MEMB_FEED_CTRL_PERF_EN
  logic [15:0]  stall_cycles;
`endif

  memb_feed_ctrl #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .row_valid (row_valid),
    .row_data  (row_data),
    .row_ready (row_ready),
    .sa_ready  (sa_ready),
    .memb_en   (memb_en),
    .memb_bin  (memb_bin),
    .busy      (busy),
    .done      (done)
`ifdef MEMB_FEED_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_cnt  = 0;
  int           m_seq  = 0;
  int           src_idx = 0;
  logic [W-1:0] exp_q[$];

  // Values sampled in the last cycle
  logic         s_en;
  logic         s_done;
  logic [W-1:0] s_bin;

  function automatic logic [W-1:0] row_val(input int seq, input int r);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++)
      v[i*BITS_AB +: BITS_AB] = BITS_AB'((seq * 29 + r * DIM + i) % 200 + 1);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic do_cycle(input logic st, input logic vld, input logic sa, input logic rs);
    logic in_feed;
    logic exp_en;
    logic exp_rr;
    logic [W-1:0] exp_row;
    start     = st;
    row_valid = vld;
    sa_ready  = sa;
    rst       = rs;
    row_data  = row_val(m_seq, src_idx);
    #4;
    in_feed = m_busy && (m_cnt < DIM);
    exp_en  = m_busy && sa && (in_feed ? vld : 1'b1);
    exp_rr  = in_feed && sa;
    chk("memb_en", W'(memb_en), W'(exp_en));
    chk("row_ready", W'(row_ready), W'(exp_rr));
    chk("busy", W'(busy), W'(m_busy));
    chk("done", W'(done), W'(m_done));
    if (memb_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", W'(1), W'(0));
      end else begin
        exp_row = exp_q.pop_front();
        chk("memb_bin", memb_bin, exp_row);
      end
    end else begin
      chk("memb_bin_idle", memb_bin, '0);
    end
    s_en   = memb_en;
    s_done = done;
    s_bin  = memb_bin;
    @(posedge clk);
    #1;
    if (rs) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_done = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (st) begin
          m_busy  = 1'b1;
          m_cnt   = 0;
          m_seq++;
          src_idx = 0;
          for (int r = 0; r < DIM; r++) exp_q.push_back(row_val(m_seq, r));
          for (int z = 0; z < 2 * DIM - 1; z++) exp_q.push_back('0);
        end
      end else if (exp_en) begin
        if (in_feed) src_idx++;
        m_cnt++;
        if (m_cnt == 3 * DIM - 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  // Run n cycles with optional start pulses, one-cycle source gaps,
  // an sa_ready low window and a one-cycle reset (-1 disables each).
  task automatic run_seq(input string name, input int n, input int st_a, input int st_b,
                         input int gap_a, input int gap_b, input int lo_from, input int lo_len,
                         input int rst_at, output int first_done, output int last_done,
                         output int n_done, output int zero_beats);
    logic st, vld, sa, rs;
    first_done = -1;
    last_done  = -1;
    n_done     = 0;
    zero_beats = 0;
    for (int t = 0; t < n; t++) begin
      st  = (t == st_a) || (t == st_b);
      vld = !((t == gap_a) || (t == gap_b));
      sa  = !((t >= lo_from) && (t < lo_from + lo_len));
      rs  = (t == rst_at);
      do_cycle(st, vld, sa, rs);
      if (s_done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = t;
        last_done = t;
      end
      if ((s_en === 1'b1) && (s_bin == '0)) zero_beats++;
    end
    $display("seq %s: first_done=%0d last_done=%0d dones=%0d zero_beats=%0d",
             name, first_done, last_done, n_done, zero_beats);
  endtask

  int fd, ld, nd, zb;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    row_valid = 1'b0;
    sa_ready  = 1'b0;
    row_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with row_valid asserted outside FEED
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0);

    // Stall-free sequence
    run_seq("stall_free", 30, 0, -1, -1, -1, -1, 0, -1, fd, ld, nd, zb);
    chk("sf_done_cycle", W'(fd), W'(24));
    chk("sf_done_count", W'(nd), W'(1));
    chk("sf_zero_beats", W'(zb), W'(15));
    chk("sf_queue_empty", W'(exp_q.size()), W'(0));

    // Source gaps before rows 3 and 6
    run_seq("src_gaps", 32, 0, -1, 4, 8, -1, 0, -1, fd, ld, nd, zb);
    chk("gap_done_cycle", W'(fd), W'(26));
    chk("gap_queue_empty", W'(exp_q.size()), W'(0));

    // Array back-pressure mid-FLUSH
    run_seq("backpressure", 34, 0, -1, -1, -1, 12, 4, -1, fd, ld, nd, zb);
    chk("bp_done_cycle", W'(fd), W'(28));
    chk("bp_zero_beats", W'(zb), W'(15));

    // Reset mid-FEED after row 4, then a clean sequence
    run_seq("reset_mid_feed", 40, 0, -1, -1, -1, -1, 0, 6, fd, ld, nd, zb);
    chk("rst_no_done", W'(nd), W'(0));
    run_seq("after_reset", 30, 0, -1, -1, -1, -1, 0, -1, fd, ld, nd, zb);
    chk("ar_done_cycle", W'(fd), W'(24));
    chk("ar_zero_beats", W'(zb), W'(15));

    // start while busy is ignored
    run_seq("start_busy", 40, 0, 10, -1, -1, -1, 0, -1, fd, ld, nd, zb);
    chk("sb_done_count", W'(nd), W'(1));
    chk("sb_done_cycle", W'(fd), W'(24));

    // start in the done cycle begins the next sequence immediately
    run_seq("start_in_done", 54, 0, 24, -1, -1, -1, 0, -1, fd, ld, nd, zb);
    chk("sd_done_count", W'(nd), W'(2));
    chk("sd_second_done", W'(ld), W'(48));

`ifdef MEMB_FEED_CTRL_PERF_EN
    run_seq("perf", 34, 0, -1, -1, -1, 3, 5, -1, fd, ld, nd, zb);
    chk("perf_done_cycle", W'(fd), W'(29));
    chk("perf_stall_cycles", W'(stall_cycles), W'(5));
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("perf_stall_clear", W'(stall_cycles), W'(0));
    run_seq("perf_drain", 30, -1, -1, -1, -1, -1, 0, -1, fd, ld, nd, zb);
    chk("perf_drain_done", W'(fd), W'(23));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
